// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the two-player guessing game sequencer:
// controller states, decision codes, winner codes and grant encodings.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TURN     = 3'd1,
        S_WAIT_RES = 3'd2,
        S_SCORE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Decision codes returned by the external decision datapath.
    typedef enum logic [1:0] {
        RES_PENDING = 2'b00,
        RES_CORRECT = 2'b01,
        RES_WRONG   = 2'b10,
        RES_ABORT   = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_P1    = 2'b01,
        WIN_P2    = 2'b10,
        WIN_ABORT = 2'b11
    } winner_t;

    // One-hot turn owner; 2'b11 is never produced.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P1   = 2'b01;
    localparam logic [1:0] GRANT_P2   = 2'b10;

    localparam int unsigned TIMER_W = 8;

    // Score increment that sticks at the 4-bit maximum.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_turn_timer.sv
// Loadable down-counter. o_expire flags that the current tick is the last
// one (the count reaches zero on it), so a load of N yields N ticks.
module turn_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_tick,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over counting; the count stops at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count <= WIDTH'(1));

endmodule

// File: rtl/game_sequencer.sv
// Two-player turn sequencer: grants turns, forwards the owner's guess,
// waits for a decision code, keeps score and declares the match winner.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned TURN_TICKS = 16,
    parameter int unsigned RES_WAIT   = 4,
    parameter int unsigned WIN_SCORE  = 5
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Guess_p1,
    input  logic       Guess_p2,
    input  logic [1:0] Result,
    output logic [1:0] Grant,
    output logic       Guess_fwd,
    output logic [3:0] Score_p1,
    output logic [3:0] Score_p2,
    output logic [1:0] Winner,
    output logic       Busy
);

    state_t      r_state;
    logic [1:0]  r_grant;
    logic        r_fwd;
    logic [3:0]  r_score_p1;
    logic [3:0]  r_score_p2;
    winner_t     r_winner;
    logic        r_busy;
    result_t     r_code;

    logic        w_accept;
    logic        w_decided;
    result_t     w_code;
    logic [3:0]  w_owner_score;
    logic [3:0]  w_new_score;
    logic        w_turn_load;
    logic        w_turn_tick;
    logic        w_turn_exp;
    logic        w_wait_load;
    logic        w_wait_tick;
    logic        w_wait_exp;

    // Guess acceptance, decision decode, score preview and timer controls.
    always_comb begin
        w_accept  = (r_state == S_TURN) &&
                    (((r_grant == GRANT_P1) && Guess_p1) ||
                     ((r_grant == GRANT_P2) && Guess_p2));

        // x/z and 00 match no item and so read as pending.
        w_decided = 1'b0;
        w_code    = RES_WRONG;
        case (Result)
            RES_CORRECT: begin w_decided = 1'b1; w_code = RES_CORRECT; end
            RES_WRONG:   begin w_decided = 1'b1; w_code = RES_WRONG;   end
            RES_ABORT:   begin w_decided = 1'b1; w_code = RES_ABORT;   end
            default:     begin w_decided = 1'b0; w_code = RES_WRONG;   end
        endcase

        w_owner_score = (r_grant == GRANT_P1) ? r_score_p1 : r_score_p2;
        w_new_score   = (r_code == RES_CORRECT) ? sat_inc4(w_owner_score)
                                                : w_owner_score;

        w_turn_load = (((r_state == S_IDLE) || (r_state == S_DONE)) && Start) ||
                      ((r_state == S_TURN) && !w_accept && w_turn_exp) ||
                      (r_state == S_SCORE);
        w_turn_tick = (r_state == S_TURN);

        // The wait counter only runs once the forward strobe has gone, so
        // Result is never sampled in the Guess_fwd cycle.
        w_wait_load = w_accept;
        w_wait_tick = (r_state == S_WAIT_RES) && !r_fwd;
    end

    turn_timer #(.WIDTH(TIMER_W)) u_turn_timer (
        .i_clk      (Clock),
        .i_rst_n    (Reset_n),
        .i_load     (w_turn_load),
        .i_load_val (TIMER_W'(TURN_TICKS)),
        .i_tick     (w_turn_tick),
        .o_expire   (w_turn_exp)
    );

    turn_timer #(.WIDTH(TIMER_W)) u_wait_timer (
        .i_clk      (Clock),
        .i_rst_n    (Reset_n),
        .i_load     (w_wait_load),
        .i_load_val (TIMER_W'(RES_WAIT)),
        .i_tick     (w_wait_tick),
        .o_expire   (w_wait_exp)
    );

    // Match controller with registered outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_grant    <= GRANT_NONE;
            r_fwd      <= 1'b0;
            r_score_p1 <= '0;
            r_score_p2 <= '0;
            r_winner   <= WIN_NONE;
            r_busy     <= 1'b0;
            r_code     <= RES_PENDING;
        end else begin
            r_fwd <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_state    <= S_TURN;
                        r_grant    <= GRANT_P1;
                        r_score_p1 <= '0;
                        r_score_p2 <= '0;
                        r_winner   <= WIN_NONE;
                        r_busy     <= 1'b1;
                    end
                end
                S_TURN: begin
                    // A guess in the expiry cycle keeps the turn.
                    if (w_accept) begin
                        r_fwd   <= 1'b1;
                        r_state <= S_WAIT_RES;
                    end else if (w_turn_exp) begin
                        r_grant <= (r_grant == GRANT_P1) ? GRANT_P2 : GRANT_P1;
                    end
                end
                S_WAIT_RES: begin
                    if (!r_fwd) begin
                        if (w_decided) begin
                            r_code  <= w_code;
                            r_state <= S_SCORE;
                        end else if (w_wait_exp) begin
                            r_code  <= RES_WRONG;
                            r_state <= S_SCORE;
                        end
                    end
                end
                S_SCORE: begin
                    if (r_code == RES_ABORT) begin
                        r_winner <= WIN_ABORT;
                        r_grant  <= GRANT_NONE;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        if (r_grant == GRANT_P1) r_score_p1 <= w_new_score;
                        else                     r_score_p2 <= w_new_score;
                        if (w_new_score == 4'(WIN_SCORE)) begin
                            r_winner <= (r_grant == GRANT_P1) ? WIN_P1 : WIN_P2;
                            r_grant  <= GRANT_NONE;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_grant  <= (r_grant == GRANT_P1) ? GRANT_P2 : GRANT_P1;
                            r_state  <= S_TURN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= GRANT_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Grant     = r_grant;
    assign Guess_fwd = r_fwd;
    assign Score_p1  = r_score_p1;
    assign Score_p2  = r_score_p2;
    assign Winner    = r_winner;
    assign Busy      = r_busy;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios followed by
// randomized matches, checked every cycle against a turn-level game model.
module tb_game_sequencer;

    localparam int TT = 16;
    localparam int RW = 4;
    localparam int WS = 5;

    logic       Clock;
    logic       Reset_n;
    logic       Start;
    logic       Guess_p1;
    logic       Guess_p2;
    logic [1:0] Result;
    logic [1:0] Grant;
    logic       Guess_fwd;
    logic [3:0] Score_p1;
    logic [3:0] Score_p2;
    logic [1:0] Winner;
    logic       Busy;

    game_sequencer #(
        .TURN_TICKS (TT),
        .RES_WAIT   (RW),
        .WIN_SCORE  (WS)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Guess_p1  (Guess_p1),
        .Guess_p2  (Guess_p2),
        .Result    (Result),
        .Grant     (Grant),
        .Guess_fwd (Guess_fwd),
        .Score_p1  (Score_p1),
        .Score_p2  (Score_p2),
        .Winner    (Winner),
        .Busy      (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish before 1000000 ns");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_mis = 0;

    // Game-level model: who holds the turn, idle cycles spent in it,
    // scores, winner, and whether a match is in progress.
    bit m_active;
    int m_owner;
    int m_elapsed;
    int m_sc1, m_sc2;
    int m_win;
    bit m_fwd;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " grant"},  8'(Grant),     m_active ? 8'(m_owner) : 8'd0);
        chk({tag, " fwd"},    8'(Guess_fwd), 8'(m_fwd));
        chk({tag, " score1"}, 8'(Score_p1),  8'(m_sc1));
        chk({tag, " score2"}, 8'(Score_p2),  8'(m_sc2));
        chk({tag, " winner"}, 8'(Winner),    8'(m_win));
        chk({tag, " busy"},   8'(Busy),      8'(m_active));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic void model_reset();
        m_active = 0; m_owner = 1; m_elapsed = 0;
        m_sc1 = 0; m_sc2 = 0; m_win = 0; m_fwd = 0;
    endfunction

    function automatic void model_start();
        if (!m_active) begin
            m_active = 1; m_owner = 1; m_elapsed = 0;
            m_sc1 = 0; m_sc2 = 0; m_win = 0;
        end
        m_fwd = 0;
    endfunction

    task automatic start_match();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        model_start();
        check_all("start");
    endtask

    task automatic hard_reset();
        #2 Reset_n = 1'b0;
        Start = 0; Guess_p1 = 0; Guess_p2 = 0; Result = 2'b00;
        tick();
        @(negedge Clock);
        Reset_n = 1'b1;
        model_reset();
        tick();
        check_all("hard_rst");
    endtask

    // Cycles with no owner guess; optional noise from the other player
    // and stray Start pulses, or from both players when no match runs.
    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            Guess_p1 = 0; Guess_p2 = 0; Start = 0;
            if (noise) begin
                if (m_active) begin
                    if (m_owner == 1) Guess_p2 = 1'($urandom_range(0, 1));
                    else              Guess_p1 = 1'($urandom_range(0, 1));
                    Start = ($urandom_range(0, 7) == 0);
                end else begin
                    Guess_p1 = 1'($urandom_range(0, 1));
                    Guess_p2 = 1'($urandom_range(0, 1));
                end
            end
            tick();
            if (m_active) begin
                m_elapsed++;
                if (m_elapsed == TT) begin
                    m_owner   = 3 - m_owner;
                    m_elapsed = 0;
                end
            end
            m_fwd = 0;
            check_all("idle");
        end
        Guess_p1 = 0; Guess_p2 = 0; Start = 0;
    endtask

    // Owner guesses now; the decision appears after p pending sample
    // cycles (p >= RW means it never arrives). decoy drives a code during
    // the forward cycle, which must be ignored. zpend uses z as pending.
    task automatic guess(input int p, input logic [1:0] code, input bit decoy, input bit zpend);
        logic [1:0] pend;
        int eff;
        pend = zpend ? 2'bzz : 2'b00;
        if (m_owner == 1) begin Guess_p1 = 1; Guess_p2 = 1'($urandom_range(0, 1)); end
        else              begin Guess_p2 = 1; Guess_p1 = 1'($urandom_range(0, 1)); end
        tick();
        Guess_p1 = 0; Guess_p2 = 0;
        m_fwd = 1;
        check_all("fwd");
        Result = decoy ? 2'($urandom_range(1, 3)) : pend;
        tick();
        m_fwd = 0;
        check_all("wait0");
        Result = pend;
        for (int i = 0; i < RW; i++) begin
            if (i == p) Result = code;
            Guess_p1 = 1'($urandom_range(0, 1));
            Guess_p2 = 1'($urandom_range(0, 1));
            tick();
            Result = pend;
            Guess_p1 = 0; Guess_p2 = 0;
            check_all("wait");
            if (i == p) break;
        end
        tick();
        eff = (p < RW) ? int'(code) : 2;
        if (eff == 3) begin
            m_win = 3; m_active = 0;
        end else begin
            if (eff == 1) begin
                if (m_owner == 1) m_sc1 = (m_sc1 < 15) ? m_sc1 + 1 : 15;
                else              m_sc2 = (m_sc2 < 15) ? m_sc2 + 1 : 15;
            end
            if (((m_owner == 1) ? m_sc1 : m_sc2) == WS) begin
                m_win = m_owner; m_active = 0;
            end else begin
                m_owner = 3 - m_owner; m_elapsed = 0;
            end
        end
        check_all("score");
        Result = 2'b00;
    endtask

    initial begin
        int pp, rc;
        logic [1:0] cd;
        Reset_n = 0; Start = 0; Guess_p1 = 0; Guess_p2 = 0; Result = 2'b00;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all("por");

        // Release mid-cycle with Start already high: honoured at next edge.
        @(negedge Clock);
        Reset_n = 1; Start = 1;
        tick();
        Start = 0;
        model_start();
        check_all("start_after_rel");

        // Reset mid-turn (P1, 7 ticks left), with a P1 strobe held.
        idle(9, 0);
        #2 Reset_n = 0; Guess_p1 = 1;
        #1 model_reset();
        check_all("rst_async_turn");
        @(negedge Clock);
        Reset_n = 1;
        repeat (3) begin tick(); check_all("post_rst_turn"); end
        Guess_p1 = 0;

        // Reset mid-wait: the pending guess is dropped.
        start_match();
        Guess_p1 = 1;
        tick();
        Guess_p1 = 0;
        m_fwd = 1;
        check_all("fwd_before_rst");
        #2 Reset_n = 0;
        #1 model_reset();
        check_all("rst_async_wait");
        @(negedge Clock);
        Reset_n = 1; Result = 2'b01;
        repeat (3) begin tick(); check_all("post_rst_wait"); end
        Result = 2'b00;

        // Correct guess two cycles after the strobe.
        start_match();
        guess(0, 2'b01, 0, 0);

        // Turn expiry; P2 strobe in P1's last cycle is ignored; P2 then
        // guesses in its own expiry cycle and keeps the turn.
        hard_reset();
        start_match();
        idle(15, 0);
        Guess_p2 = 1;
        tick();
        Guess_p2 = 0;
        m_elapsed++;
        if (m_elapsed == TT) begin m_owner = 3 - m_owner; m_elapsed = 0; end
        check_all("expiry_swap");
        idle(TT - 1, 0);
        guess(1, 2'b10, 0, 0);

        // No decision within the wait window: wrong.
        hard_reset();
        start_match();
        guess(RW, 2'b01, 0, 1);

        // Alternating correct guesses until P1 wins; DONE ignores strobes.
        hard_reset();
        start_match();
        for (int k = 0; k < 9; k++)
            guess($urandom_range(0, RW - 1), 2'b01, 1'($urandom_range(0, 1)), 0);
        idle(6, 1);

        // Restart from DONE, then abort on the first guess, then restart.
        start_match();
        guess(0, 2'b11, 0, 0);
        idle(3, 1);
        start_match();
        idle(2, 0);

        // Randomized matches.
        for (int m = 0; m < 10; m++) begin
            start_match();
            for (int g = 0; g < 40 && m_active; g++) begin
                idle($urandom_range(0, 20), 1);
                pp = $urandom_range(0, RW + 1);
                rc = $urandom_range(0, 9);
                cd = (rc == 0) ? 2'b11 : (rc <= 6) ? 2'b01 : 2'b10;
                guess(pp, cd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            idle(3, 1);
            if (m == 4) hard_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
